// File: rtl/sum_accumulator_if.sv
// rtl/sum_accumulator_if.sv - handshake and result bundle between adder, accumulator and consumer
interface sum_accumulator_if #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 16,
    parameter int COUNT_W = 8
);
    logic               start;
    logic [COUNT_W-1:0] num_samples;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_sum;
    logic               in_cout;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_acc;
    logic               out_ovf;
    logic               busy;

    modport master (
        output start, num_samples, in_valid, in_sum, in_cout, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf, busy
    );

    modport slave (
        input  start, num_samples, in_valid, in_sum, in_cout, out_ready,
        output in_ready, out_valid, out_acc, out_ovf, busy
    );
endinterface

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - accumulates a programmed number of {cout,sum} adder results; SUM_ACCUMULATOR_SATURATE_EN selects clamping
module sum_accumulator #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 16,
    parameter int COUNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sum_accumulator_if.slave      bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]         state;
    logic [ACC_W-1:0]   acc;
    logic [COUNT_W-1:0] cnt;
    logic               ovf;

    logic [ACC_W-1:0]   operand;
    logic [ACC_W:0]     sum_ext;
    logic [ACC_W-1:0]   acc_next;
    logic               beat;

    // Operand is the 9-bit adder result, zero-extended to the accumulator width
    assign operand = {{(ACC_W-DATA_W-1){1'b0}}, bus.in_cout, bus.in_sum};
    assign sum_ext = {1'b0, acc} + {1'b0, operand};
    assign beat    = (state == ST_ACCUM) && bus.in_valid;

    // Next accumulator value: clamp once overflowed, or wrap modulo 2^ACC_W
    always_comb begin
        acc_next = sum_ext[ACC_W-1:0];
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        if (sum_ext[ACC_W] || ovf) begin
            acc_next = {ACC_W{1'b1}};
        end
`endif
    end

    // Run control: start a run in IDLE, count accepted beats, hold total until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= bus.num_samples;
                        state <= (bus.num_samples == '0) ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (beat) begin
                        acc <= acc_next;
                        cnt <= cnt - COUNT_W'(1);
                        if (sum_ext[ACC_W]) begin
                            ovf <= 1'b1;
                        end
                        if (cnt == COUNT_W'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from state and registers so reset clears them at once
    assign bus.in_ready  = (state == ST_ACCUM);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.out_acc   = acc;
    assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - directed self-checking bench for sum_accumulator
module tb_sum_accumulator;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    sum_accumulator_if #(.DATA_W(8), .ACC_W(16), .COUNT_W(8)) bus ();

    sum_accumulator #(.DATA_W(8), .ACC_W(16), .COUNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_run(input logic [7:0] n);
        bus.start       = 1'b1;
        bus.num_samples = n;
        tick();
        bus.start       = 1'b0;
    endtask

    task automatic beat(input logic c, input logic [7:0] s);
        bus.in_valid = 1'b1;
        bus.in_cout  = c;
        bus.in_sum   = s;
        check("beat_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("take_out_valid", 32'(bus.out_valid), 32'd0);
        check("take_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [15:0] exp_t2;
        n_cmp = 0;
        n_bad = 0;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.num_samples = '0;
        bus.in_valid    = 1'b0;
        bus.in_sum      = '0;
        bus.in_cout     = 1'b0;
        bus.out_ready   = 1'b0;
        tick();
        tick();

        // reset state
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_acc", 32'(bus.out_acc), 32'd0);
        check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: three beats
        start_run(8'd3);
        check("t1_busy", 32'(bus.busy), 32'd1);
        beat(1'b0, 8'h10);
        beat(1'b0, 8'h20);
        check("t1_not_done", 32'(bus.out_valid), 32'd0);
        beat(1'b1, 8'hFF);
        check("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check("t1_out_acc", 32'(bus.out_acc), 32'h022F);
        check("t1_out_ovf", 32'(bus.out_ovf), 32'd0);
        take_result();

        // 2: 255 maximal beats
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        exp_t2 = 16'hFFFF;
`else
        exp_t2 = 16'hFD01;
`endif
        start_run(8'd255);
        for (int i = 0; i < 255; i++) begin
            beat(1'b1, 8'hFF);
        end
        check("t2_out_valid", 32'(bus.out_valid), 32'd1);
        check("t2_out_acc", 32'(bus.out_acc), 32'(exp_t2));
        check("t2_out_ovf", 32'(bus.out_ovf), 32'd1);
        take_result();

        // 3: bubbles between beats are not counted; ovf cleared by new start
        start_run(8'd2);
        check("t3_ovf_cleared", 32'(bus.out_ovf), 32'd0);
        beat(1'b0, 8'h05);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_bubble_valid", 32'(bus.out_valid), 32'd0);
            check("t3_bubble_ready", 32'(bus.in_ready), 32'd1);
        end
        beat(1'b0, 8'h07);
        check("t3_out_valid", 32'(bus.out_valid), 32'd1);
        check("t3_out_acc", 32'(bus.out_acc), 32'h000C);

        // 4: hold in DONE, start and in_valid ignored, start with out_ready not seen
        take_result();
        start_run(8'd1);
        beat(1'b0, 8'h33);
        bus.in_valid = 1'b1;
        bus.in_sum   = 8'h44;
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 2);
            tick();
            check("t4_hold_valid", 32'(bus.out_valid), 32'd1);
            check("t4_hold_acc", 32'(bus.out_acc), 32'h0033);
            check("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        check("t4_idle_valid", 32'(bus.out_valid), 32'd0);
        check("t4_idle_busy", 32'(bus.busy), 32'd0);
        tick();
        check("t4_still_idle", 32'(bus.busy), 32'd0);
        check("t4_idle_no_ready", 32'(bus.in_ready), 32'd0);
        check("t4_acc_untouched", 32'(bus.out_acc), 32'h0033);
        bus.in_valid = 1'b0;

        // 5: zero-length run
        start_run(8'd0);
        check("t5_out_valid", 32'(bus.out_valid), 32'd1);
        check("t5_out_acc", 32'(bus.out_acc), 32'd0);
        check("t5_out_ovf", 32'(bus.out_ovf), 32'd0);
        take_result();

        // 6: reset mid-run, then a fresh run
        start_run(8'd4);
        beat(1'b0, 8'h11);
        beat(1'b1, 8'h22);
        rst_n = 1'b0;
        #1;
        check("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        check("t6_rst_out_acc", 32'(bus.out_acc), 32'd0);
        check("t6_rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_run(8'd1);
        beat(1'b0, 8'h01);
        check("t6_out_valid", 32'(bus.out_valid), 32'd1);
        check("t6_out_acc", 32'(bus.out_acc), 32'h0001);
        take_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
